// File: rtl/branch_resolve_queue.sv
// rtl/branch_resolve_queue.sv - branch/jump resolver with a buffered resolution queue toward the frontend
//
// Purpose:
//   Resolves conditional branches, JAL and JALR ops (target, link value, taken,
//   mispredict, misaligned-target exception, cf type and expected JIT domain),
//   pushes each resolution into a DEPTH-entry FIFO and drains the FIFO to the
//   frontend (PC gen / BHT / BTB) under valid/ready backpressure. After a
//   mispredicting or faulting op is queued, younger ops are accepted and
//   discarded until flush_i.
//
// Ports:
//   clk_i, rst_i (async, active-high), flush_i (empty FIFO, leave squash)
//   in_valid_i / in_ready_o            op handshake
//   in_branch_i, in_regjump_i, in_domchg_i, in_cmp_i, in_rvc_i   op kind/flags
//   in_pc_i, in_opa_i, in_imm_i, in_paddr_i                      addresses
//   in_pcf_i (0 NoCF, 1 Branch, 2 Jump, 3 JumpR, 4 Return)       predicted cf
//   in_curdom_i, in_datadom_i, in_tag_i                          domain / tag
//   out_valid_o / out_ready_i          FIFO head handshake
//   out_pc_o, out_target_o, out_link_o, out_taken_o, out_misp_o,
//   out_exc_o, out_cf_o, out_expdom_o, out_tag_o                 head fields
//
// Optional feature (macro BRQ_STATS_EN):
//   adds stat_resolved_o / stat_misp_o, saturating pop counters cleared only by reset.

module branch_resolve_queue #(
  parameter int VLEN  = 64,
  parameter int DEPTH = 4,
  parameter int DOM_W = 4,
  parameter int TAG_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             in_branch_i,
  input  logic             in_regjump_i,
  input  logic             in_domchg_i,
  input  logic             in_cmp_i,
  input  logic             in_rvc_i,
  input  logic [VLEN-1:0]  in_pc_i,
  input  logic [VLEN-1:0]  in_opa_i,
  input  logic [VLEN-1:0]  in_imm_i,
  input  logic [2:0]       in_pcf_i,
  input  logic [VLEN-1:0]  in_paddr_i,
  input  logic [DOM_W-1:0] in_curdom_i,
  input  logic [DOM_W-1:0] in_datadom_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [VLEN-1:0]  out_pc_o,
  output logic [VLEN-1:0]  out_target_o,
  output logic [VLEN-1:0]  out_link_o,
  output logic             out_taken_o,
  output logic             out_misp_o,
  output logic             out_exc_o,
  output logic [2:0]       out_cf_o,
  output logic [DOM_W-1:0] out_expdom_o,
  output logic [TAG_W-1:0] out_tag_o
`ifdef BRQ_STATS_EN
  ,
  output logic [31:0]      stat_resolved_o,
  output logic [31:0]      stat_misp_o
`endif
);

  localparam int          PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  localparam logic [2:0] CF_NOCF   = 3'd0;
  localparam logic [2:0] CF_BRANCH = 3'd1;
  localparam logic [2:0] CF_JUMPR  = 3'd3;
  localparam logic [2:0] CF_RETURN = 3'd4;

  typedef struct packed {
    logic [VLEN-1:0]  pc;
    logic [VLEN-1:0]  target;
    logic [VLEN-1:0]  link;
    logic             taken;
    logic             misp;
    logic             exc;
    logic [2:0]       cf;
    logic [DOM_W-1:0] expdom;
    logic [TAG_W-1:0] tag;
  } entry_t;

  typedef enum logic {S_RUN = 1'b0, S_SQUASH = 1'b1} state_t;

  state_t          state_q, state_d;
  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  entry_t          hold_q, hold_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]     count_q, count_d;

  entry_t          new_e;
  entry_t          head;
  logic [VLEN-1:0] base;
  logic [VLEN-1:0] dest;
  logic [VLEN-1:0] link;
  logic            do_push;
  logic            do_pop;

  // Resolution of the op currently on the input port.
  always_comb begin
    base = in_regjump_i ? in_opa_i : in_pc_i;
    dest = base + in_imm_i;
    if (in_regjump_i) dest[0] = 1'b0;
    link = in_pc_i + (in_rvc_i ? VLEN'(2) : VLEN'(4));

    new_e        = '0;
    new_e.pc     = in_pc_i;
    new_e.link   = link;
    new_e.tag    = in_tag_i;
    new_e.taken  = in_branch_i ? in_cmp_i : 1'b1;
    new_e.target = (in_branch_i && !in_cmp_i) ? link : dest;
    // Fall-through (link) is always aligned enough, so only a taken target can fault.
    new_e.exc    = dest[0] & new_e.taken;
    new_e.cf     = in_pcf_i;
    new_e.expdom = in_curdom_i;
    new_e.misp   = 1'b0;
    if (in_branch_i) begin
      new_e.cf   = CF_BRANCH;
      new_e.misp = in_cmp_i != (in_pcf_i == CF_BRANCH);
    end else if (in_regjump_i && ((in_pcf_i == CF_NOCF) || (dest != in_paddr_i))) begin
      new_e.misp   = 1'b1;
      new_e.cf     = (in_pcf_i == CF_RETURN) ? CF_RETURN : CF_JUMPR;
      new_e.expdom = in_domchg_i ? in_datadom_i : in_curdom_i;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_RUN;
    else       state_q <= state_d;
  end

  // FSM next state. do_push already excludes flush cycles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:    if (do_push && (new_e.misp || new_e.exc)) state_d = S_SQUASH;
      S_SQUASH: if (flush_i) state_d = S_RUN;
      default:  state_d = S_RUN;
    endcase
  end

  // FSM outputs and handshake decode. In SQUASH every op is accepted and dropped.
  always_comb begin
    out_valid_o = (count_q != '0);
    in_ready_o  = (count_q < FULL_CNT) || (out_valid_o && out_ready_i) || (state_q == S_SQUASH);
    do_pop      = out_valid_o && out_ready_i && !flush_i;
    do_push     = in_valid_i && in_ready_o && !flush_i && (state_q == S_RUN);
  end

  // FIFO bookkeeping; pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    hold_d   = hold_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = new_e;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        hold_d   = mem_q[rd_ptr_q];
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (PW + 1)'(1);
        2'b01:   count_d = count_q - (PW + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      hold_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      hold_q   <= hold_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // When empty the outputs keep showing the last popped entry.
  assign head         = out_valid_o ? mem_q[rd_ptr_q] : hold_q;
  assign out_pc_o     = head.pc;
  assign out_target_o = head.target;
  assign out_link_o   = head.link;
  assign out_taken_o  = head.taken;
  assign out_misp_o   = head.misp;
  assign out_exc_o    = head.exc;
  assign out_cf_o     = head.cf;
  assign out_expdom_o = head.expdom;
  assign out_tag_o    = head.tag;

`ifdef BRQ_STATS_EN
  logic [31:0] stat_resolved_q, stat_resolved_d;
  logic [31:0] stat_misp_q, stat_misp_d;

  always_comb begin
    stat_resolved_d = stat_resolved_q;
    stat_misp_d     = stat_misp_q;
    if (do_pop && (stat_resolved_q != '1)) stat_resolved_d = stat_resolved_q + 32'd1;
    if (do_pop && mem_q[rd_ptr_q].misp && (stat_misp_q != '1)) stat_misp_d = stat_misp_q + 32'd1;
  end

  // Flush deliberately leaves these alone; only reset clears them.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_resolved_q <= '0;
      stat_misp_q     <= '0;
    end else begin
      stat_resolved_q <= stat_resolved_d;
      stat_misp_q     <= stat_misp_d;
    end
  end

  assign stat_resolved_o = stat_resolved_q;
  assign stat_misp_o     = stat_misp_q;
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb/tb_branch_resolve_queue.sv - self-checking bench for branch_resolve_queue
module tb_branch_resolve_queue;

  localparam int VLEN  = 64;
  localparam int DEPTH = 4;
  localparam int DOM_W = 4;
  localparam int TAG_W = 3;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic        in_branch, in_regjump, in_domchg, in_cmp, in_rvc;
  logic [63:0] in_pc, in_opa, in_imm, in_paddr;
  logic [2:0]  in_pcf;
  logic [3:0]  in_curdom, in_datadom;
  logic [2:0]  in_tag;
  logic        out_valid, out_ready;
  logic [63:0] out_pc, out_target, out_link;
  logic        out_taken, out_misp, out_exc;
  logic [2:0]  out_cf;
  logic [3:0]  out_expdom;
  logic [2:0]  out_tag;
`ifdef BRQ_STATS_EN
  logic [31:0] stat_res, stat_misp;
`endif

  always #5 clk = ~clk;

  branch_resolve_queue #(.VLEN(VLEN), .DEPTH(DEPTH), .DOM_W(DOM_W), .TAG_W(TAG_W)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_branch_i(in_branch), .in_regjump_i(in_regjump), .in_domchg_i(in_domchg),
    .in_cmp_i(in_cmp), .in_rvc_i(in_rvc),
    .in_pc_i(in_pc), .in_opa_i(in_opa), .in_imm_i(in_imm),
    .in_pcf_i(in_pcf), .in_paddr_i(in_paddr),
    .in_curdom_i(in_curdom), .in_datadom_i(in_datadom), .in_tag_i(in_tag),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_pc_o(out_pc), .out_target_o(out_target), .out_link_o(out_link),
    .out_taken_o(out_taken), .out_misp_o(out_misp), .out_exc_o(out_exc),
    .out_cf_o(out_cf), .out_expdom_o(out_expdom), .out_tag_o(out_tag)
`ifdef BRQ_STATS_EN
    , .stat_resolved_o(stat_res), .stat_misp_o(stat_misp)
`endif
  );

  typedef struct packed {
    logic        branch, regjump, domchg, cmp, rvc;
    logic [63:0] pc, opa, imm, paddr;
    logic [2:0]  pcf;
    logic [3:0]  curdom, datadom;
    logic [2:0]  tag;
  } op_t;

  typedef struct packed {
    logic [63:0] pc, target, link;
    logic        taken, misp, exc;
    logic [2:0]  cf;
    logic [3:0]  expdom;
    logic [2:0]  tag;
  } res_t;

  typedef struct packed {
    op_t  op;
    res_t exp;
    logic squash;
  } vec_t;

  int   passed = 0;
  int   total  = 0;
  vec_t vecs[$];
  res_t mq[$];
  logic msq;
  int   m_pops, m_misp_pops;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  function automatic op_t mk_op(input logic br, rj, dc, cmp, rvc, input logic [63:0] pc, opa, imm,
                                input logic [2:0] pcf, input logic [63:0] paddr,
                                input logic [3:0] cur, dat, input logic [2:0] tag);
    op_t o;
    o.branch = br; o.regjump = rj; o.domchg = dc; o.cmp = cmp; o.rvc = rvc;
    o.pc = pc; o.opa = opa; o.imm = imm; o.pcf = pcf; o.paddr = paddr;
    o.curdom = cur; o.datadom = dat; o.tag = tag;
    return o;
  endfunction

  function automatic res_t mk_res(input logic [63:0] pc, target, link, input logic taken, misp, exc,
                                  input logic [2:0] cf, input logic [3:0] expdom, input logic [2:0] tag);
    res_t r;
    r.pc = pc; r.target = target; r.link = link; r.taken = taken; r.misp = misp;
    r.exc = exc; r.cf = cf; r.expdom = expdom; r.tag = tag;
    return r;
  endfunction

  task automatic add_vec(input op_t o, input res_t r, input logic sq);
    vec_t v;
    v.op = o; v.exp = r; v.squash = sq;
    vecs.push_back(v);
  endtask

  // Reference: what the frontend should learn about an op, straight from the resolution rules.
  function automatic res_t model(input op_t o);
    res_t        r;
    logic [63:0] dest;
    r.pc   = o.pc;
    r.tag  = o.tag;
    r.link = o.pc + (o.rvc ? 64'd2 : 64'd4);
    dest   = (o.regjump ? o.opa : o.pc) + o.imm;
    if (o.regjump) dest[0] = 1'b0;
    r.taken  = o.branch ? o.cmp : 1'b1;
    r.target = r.taken ? dest : r.link;
    r.exc    = r.taken && dest[0];
    r.cf     = o.pcf;
    r.expdom = o.curdom;
    r.misp   = 1'b0;
    if (o.branch) begin
      r.cf   = 3'd1;
      r.misp = ((o.pcf == 3'd1) != o.cmp);
    end else if (o.regjump && (o.pcf == 3'd0 || dest != o.paddr)) begin
      r.misp = 1'b1;
      r.cf   = (o.pcf == 3'd4) ? 3'd4 : 3'd3;
      if (o.domchg) r.expdom = o.datadom;
    end
    return r;
  endfunction

  function automatic op_t rand_op(input logic [2:0] tag);
    op_t         o;
    logic [63:0] t;
    o         = '0;
    o.pc      = {$urandom, $urandom} & ~64'd1;
    o.opa     = {$urandom, $urandom};
    o.imm     = {$urandom, $urandom} & ~64'd1;
    if ($urandom_range(0, 15) == 0) o.imm[0] = 1'b1;
    o.rvc     = 1'($urandom_range(0, 1));
    o.cmp     = 1'($urandom_range(0, 1));
    o.domchg  = 1'($urandom_range(0, 1));
    o.curdom  = 4'($urandom);
    o.datadom = 4'($urandom);
    o.tag     = tag;
    case ($urandom_range(0, 2))
      0: begin
        o.branch = 1'b1;
        o.pcf    = o.cmp ? 3'd1 : 3'd0;
        if ($urandom_range(0, 7) == 0) o.pcf = o.cmp ? 3'd0 : 3'd1;
      end
      1: begin
        o.regjump = 1'b1;
        t         = (o.opa + o.imm) & ~64'd1;
        o.paddr   = t;
        o.pcf     = ($urandom_range(0, 1) != 0) ? 3'd3 : 3'd4;
        if ($urandom_range(0, 9) == 0) o.paddr = t ^ 64'h10;
        if ($urandom_range(0, 9) == 0) o.pcf = 3'd0;
      end
      default: begin
        o.pcf = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 4)) : 3'd2;
      end
    endcase
    return o;
  endfunction

  task automatic drive_op(input op_t o);
    in_branch = o.branch; in_regjump = o.regjump; in_domchg = o.domchg;
    in_cmp = o.cmp; in_rvc = o.rvc; in_pc = o.pc; in_opa = o.opa; in_imm = o.imm;
    in_pcf = o.pcf; in_paddr = o.paddr; in_curdom = o.curdom; in_datadom = o.datadom;
    in_tag = o.tag;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_cycle();
    flush = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    flush = 1'b0;
  endtask

  task automatic check_head(input res_t e, input string nm);
    chk({nm, ".valid"},  64'(out_valid),  64'd1);
    chk({nm, ".pc"},     out_pc,          e.pc);
    chk({nm, ".target"}, out_target,      e.target);
    chk({nm, ".link"},   out_link,        e.link);
    chk({nm, ".taken"},  64'(out_taken),  64'(e.taken));
    chk({nm, ".misp"},   64'(out_misp),   64'(e.misp));
    chk({nm, ".exc"},    64'(out_exc),    64'(e.exc));
    chk({nm, ".cf"},     64'(out_cf),     64'(e.cf));
    chk({nm, ".expdom"}, 64'(out_expdom), 64'(e.expdom));
    chk({nm, ".tag"},    64'(out_tag),    64'(e.tag));
  endtask

  op_t  filler, good, bad;
  logic exp_ready, v, r, f;
  op_t  ro;
  res_t re;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive_op('0);

    filler = mk_op(0, 0, 0, 0, 0, 64'h40, 64'h0, 64'h8, 3'd2, 64'h0, 4'd0, 4'd0, 3'd7);
    bad    = mk_op(1, 0, 0, 1, 0, 64'h1000, 64'h0, 64'h40, 3'd0, 64'h0, 4'd0, 4'd0, 3'd3);

    //       br rj dc cmp rvc pc                     opa       imm      pcf   paddr     cur   dat   tag
    add_vec(mk_op(1, 0, 0, 1, 0, 64'h1000, 64'h0, 64'h40, 3'd0, 64'h0, 4'd0, 4'd0, 3'd1),
            mk_res(64'h1000, 64'h1040, 64'h1004, 1, 1, 0, 3'd1, 4'd0, 3'd1), 1);
    add_vec(mk_op(0, 1, 0, 0, 1, 64'h3000, 64'h2001, 64'h0, 3'd3, 64'h2000, 4'd2, 4'd0, 3'd2),
            mk_res(64'h3000, 64'h2000, 64'h3002, 1, 0, 0, 3'd3, 4'd2, 3'd2), 0);
    add_vec(mk_op(0, 1, 1, 0, 0, 64'h500, 64'h4000, 64'h10, 3'd0, 64'h0, 4'd1, 4'd5, 3'd3),
            mk_res(64'h500, 64'h4010, 64'h504, 1, 1, 0, 3'd3, 4'd5, 3'd3), 1);
    add_vec(mk_op(1, 0, 0, 0, 0, 64'h1000, 64'h0, 64'h41, 3'd0, 64'h0, 4'd4, 4'd0, 3'd4),
            mk_res(64'h1000, 64'h1004, 64'h1004, 0, 0, 0, 3'd1, 4'd4, 3'd4), 0);
    add_vec(mk_op(1, 0, 0, 1, 0, 64'h1000, 64'h0, 64'h41, 3'd1, 64'h0, 4'd4, 4'd0, 3'd5),
            mk_res(64'h1000, 64'h1041, 64'h1004, 1, 0, 1, 3'd1, 4'd4, 3'd5), 1);
    add_vec(mk_op(0, 1, 0, 0, 0, 64'h800, 64'h9000, 64'h4, 3'd4, 64'h9000, 4'd2, 4'd9, 3'd6),
            mk_res(64'h800, 64'h9004, 64'h804, 1, 1, 0, 3'd4, 4'd2, 3'd6), 1);
    add_vec(mk_op(0, 0, 0, 0, 0, 64'h100, 64'h0, 64'h20, 3'd2, 64'h0, 4'd3, 4'd0, 3'd7),
            mk_res(64'h100, 64'h120, 64'h104, 1, 0, 0, 3'd2, 4'd3, 3'd7), 0);
    add_vec(mk_op(0, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0, 64'h20, 3'd2, 64'h0, 4'd0, 4'd0, 3'd0),
            mk_res(64'hFFFF_FFFF_FFFF_FFF0, 64'h10, 64'hFFFF_FFFF_FFFF_FFF4, 1, 0, 0, 3'd2, 4'd0, 3'd0), 0);
    add_vec(mk_op(0, 1, 1, 0, 1, 64'h700, 64'h6000, 64'h8, 3'd3, 64'h6008, 4'd3, 4'd7, 3'd1),
            mk_res(64'h700, 64'h6008, 64'h702, 1, 0, 0, 3'd3, 4'd3, 3'd1), 0);
    add_vec(mk_op(1, 0, 0, 0, 0, 64'h2000, 64'h0, 64'h80, 3'd1, 64'h0, 4'd0, 4'd0, 3'd2),
            mk_res(64'h2000, 64'h2004, 64'h2004, 0, 1, 0, 3'd1, 4'd0, 3'd2), 1);
    add_vec(mk_op(0, 1, 0, 0, 0, 64'h10, 64'h5000, 64'h3, 3'd3, 64'h5002, 4'd0, 4'd0, 3'd3),
            mk_res(64'h10, 64'h5002, 64'h14, 1, 0, 0, 3'd3, 4'd0, 3'd3), 0);
    add_vec(mk_op(0, 0, 0, 0, 0, 64'h200, 64'h0, 64'h5, 3'd2, 64'h0, 4'd0, 4'd0, 3'd4),
            mk_res(64'h200, 64'h205, 64'h204, 1, 0, 1, 3'd2, 4'd0, 3'd4), 1);

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", 64'(out_valid), 64'd0);
    chk("rst.ready", 64'(in_ready), 64'd1);
    chk("rst.pc", out_pc, 64'd0);
    chk("rst.target", out_target, 64'd0);
    chk("rst.link", out_link, 64'd0);
    chk("rst.flags", {61'd0, out_taken, out_misp, out_exc}, 64'd0);
    chk("rst.cf_tag", {58'd0, out_cf, out_tag}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Three pops, one of them a mispredict; flush must not clear the counters.
    drive_op(filler); in_tag = 3'd1; in_valid = 1'b1; tick();
    in_tag = 3'd2; tick();
    drive_op(bad); tick();
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    chk("stats_seq.drained", 64'(out_valid), 64'd0);
`ifdef BRQ_STATS_EN
    chk("stats.resolved", 64'(stat_res), 64'd3);
    chk("stats.misp", 64'(stat_misp), 64'd1);
    flush_cycle();
    #1;
    chk("stats.resolved_after_flush", 64'(stat_res), 64'd3);
    chk("stats.misp_after_flush", 64'(stat_misp), 64'd1);
`endif

    // Table of single-op vectors; a filler op afterwards shows whether squash kicked in.
    foreach (vecs[i]) begin
      flush_cycle();
      drive_op(vecs[i].op); in_valid = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      #1;
      check_head(vecs[i].exp, $sformatf("vec%0d", i));
      drive_op(filler); in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0; out_ready = 1'b0;
      #1;
      chk($sformatf("vec%0d.after_squash", i), 64'(out_valid), 64'(!vecs[i].squash));
    end

    // Backpressure: fill, then push+pop while full, preserving order across pointer wrap.
    flush_cycle();
    good = filler;
    for (int i = 0; i < DEPTH; i++) begin
      good.tag = 3'(i);
      drive_op(good); in_valid = 1'b1;
      #1;
      chk($sformatf("fill%0d.ready", i), 64'(in_ready), 64'd1);
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("full.ready", 64'(in_ready), 64'd0);
    chk("full.head_tag", 64'(out_tag), 64'd0);
    out_ready = 1'b1;
    for (int i = 4; i < 10; i++) begin
      good.tag = 3'(i);
      drive_op(good); in_valid = 1'b1;
      #1;
      chk($sformatf("pushpop%0d.ready", i), 64'(in_ready), 64'd1);
      chk($sformatf("pushpop%0d.head_tag", i), 64'(out_tag), 64'((i - 4) & 7));
      tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      #1;
      chk($sformatf("drain%0d.valid", k), 64'(out_valid), 64'd1);
      chk($sformatf("drain%0d.tag", k), 64'(out_tag), 64'((6 + k) & 7));
      tick();
    end
    out_ready = 1'b0;
    chk("drain.empty", 64'(out_valid), 64'd0);

    // Exception-induced squash, then flush with concurrent push and pop.
    flush_cycle();
    drive_op(vecs[4].op); in_valid = 1'b1; tick();
    drive_op(filler); tick();
    flush = 1'b1; out_ready = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("flush.empty", 64'(out_valid), 64'd0);
    chk("flush.ready", 64'(in_ready), 64'd1);
    good = filler; good.tag = 3'd5;
    drive_op(good); in_valid = 1'b1; tick();
    in_valid = 1'b0;
    chk("flush.run_valid", 64'(out_valid), 64'd1);
    chk("flush.run_tag", 64'(out_tag), 64'd5);
    flush_cycle();
    chk("flush_run.empty", 64'(out_valid), 64'd0);

    // Async reset while full.
    drive_op(filler); in_valid = 1'b1;
    repeat (DEPTH) tick();
    in_valid = 1'b0;
    chk("pre_areset.ready", 64'(in_ready), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("areset.valid", 64'(out_valid), 64'd0);
    chk("areset.ready", 64'(in_ready), 64'd1);
    chk("areset.pc", out_pc, 64'd0);
    chk("areset.target", out_target, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("post_areset.valid", 64'(out_valid), 64'd0);

    // Randomized traffic against the reference queue.
    mq.delete(); msq = 1'b0; m_pops = 0; m_misp_pops = 0;
    for (int c = 0; c < 800; c++) begin
      ro = rand_op(3'(c));
      v  = ($urandom_range(0, 3) != 0);
      r  = 1'($urandom_range(0, 1));
      f  = ($urandom_range(0, 19) == 0);
      drive_op(ro); in_valid = v; out_ready = r; flush = f;
      #1;
      exp_ready = (mq.size() < DEPTH) || (mq.size() > 0 && r) || msq;
      chk($sformatf("rnd%0d.ready", c), 64'(in_ready), 64'(exp_ready));
      chk($sformatf("rnd%0d.valid", c), 64'(out_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) check_head(mq[0], $sformatf("rnd%0d", c));
      if (f) begin
        mq.delete();
        msq = 1'b0;
      end else begin
        if (mq.size() != 0 && r) begin
          re = mq.pop_front();
          m_pops++;
          if (re.misp) m_misp_pops++;
        end
        if (v && exp_ready && !msq) begin
          re = model(ro);
          mq.push_back(re);
          if (re.misp || re.exc) msq = 1'b1;
        end
      end
      tick();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
`ifdef BRQ_STATS_EN
    chk("rnd.stat_resolved", 64'(stat_res), 64'(m_pops));
    chk("rnd.stat_misp", 64'(stat_misp), 64'(m_misp_pops));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
